// File: rtl/shift_add_multiplier_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : shift_add_multiplier_pkg
// Purpose  : Shared definitions for the shift-and-add multiplier: FSM state
//            encoding and the iteration-counter width derivation.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package shift_add_multiplier_pkg;

    // FSM state encoding; 2'b11 is unused and decodes as IDLE.
    typedef logic [1:0] state_t;

    localparam state_t c_IDLE = 2'b00;
    localparam state_t c_CALC = 2'b01;
    localparam state_t c_DONE = 2'b10;

    // The counter must be able to hold the value N itself (loaded on start).
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/DUT_generated_ripple_adder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : DUT_generated_ripple_adder
// Purpose  : Combinational N-bit ripple-carry adder built from a generated
//            chain of full adders.
// Ports    : a, b  [N-1:0] in  - addends
//            cin          in  - carry into bit 0
//            sum   [N-1:0] out - a + b + cin, low N bits
//            cout         out - carry out of bit N-1
// Revision : 1.0 - initial release
// ============================================================================
module DUT_generated_ripple_adder #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    // w_carry[i] is the carry into bit i; w_carry[N] leaves the adder.
    logic [N:0] w_carry;

    assign w_carry[0] = cin;

    generate
        for (genvar i = 0; i < N; i++) begin : g_bit
            assign sum[i]         = a[i] ^ b[i] ^ w_carry[i];
            assign w_carry[i + 1] = (a[i] & b[i]) | (w_carry[i] & (a[i] ^ b[i]));
        end
    endgenerate

    assign cout = w_carry[N];

endmodule
`default_nettype wire

// File: rtl/shift_add_multiplier.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : shift_add_multiplier
// Purpose  : Sequential NxN unsigned multiplier. One conditional add and one
//            right shift of {C,A,Q} per cycle using the ripple adder; result
//            appears N+1 cycles after an accepted start.
// Ports    : clk              in  - rising-edge clock
//            rst              in  - synchronous active-high reset
//            start            in  - launch request, honoured only in IDLE
//            mcand  [N-1:0]   in  - multiplicand, captured on accepted start
//            mplier [N-1:0]   in  - multiplier, captured on accepted start
//            busy             out - high whenever not IDLE
//            done             out - one-cycle pulse, product valid
//            product[2N-1:0]  out - result, held until next completion/reset
// Revision : 1.0 - initial release
// ============================================================================
module shift_add_multiplier
    import shift_add_multiplier_pkg::*;
#(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   mcand,
    input  logic [N-1:0]   mplier,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);

    localparam int c_CNT_W = cnt_width(N);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t              r_state;
    state_t              w_state_nxt;
    logic [N-1:0]        r_m;
    logic [N-1:0]        r_a;
    logic                r_c;
    logic [N-1:0]        r_q;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [2*N-1:0]      r_product;

    // ------------------------------------------------------------------
    // Adder and shift datapath
    // ------------------------------------------------------------------
    logic [N-1:0]        w_sum;
    logic                w_cout;
    logic [2*N:0]        w_ext;
    logic [2*N:0]        w_shifted;
    logic                w_last;

    DUT_generated_ripple_adder #(
        .N    (N)
    ) u_adder (
        .a    (r_a),
        .b    (r_m),
        .cin  (1'b0),
        .sum  (w_sum),
        .cout (w_cout)
    );

    // When the multiplier LSB is set the sum replaces A (with its carry on
    // top); otherwise the word shifts unchanged. C is zero in CALC, so the
    // non-add path shifts in a zero.
    assign w_ext     = r_q[0] ? {w_cout, w_sum, r_q} : {r_c, r_a, r_q};
    assign w_shifted = w_ext >> 1;
    assign w_last    = (r_cnt == c_CNT_W'(1));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = c_IDLE;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            c_IDLE: begin
                w_state_nxt = start ? c_CALC : c_IDLE;
            end
            c_CALC: begin
                busy        = 1'b1;
                w_state_nxt = w_last ? c_DONE : c_CALC;
            end
            c_DONE: begin
                busy        = 1'b1;
                done        = 1'b1;
                w_state_nxt = c_IDLE;
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers and iteration counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_m       <= '0;
            r_a       <= '0;
            r_c       <= 1'b0;
            r_q       <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_m   <= mcand;
                        r_q   <= mplier;
                        r_a   <= '0;
                        r_c   <= 1'b0;
                        r_cnt <= c_CNT_W'(N);
                    end
                end
                c_CALC: begin
                    r_c   <= w_shifted[2*N];
                    r_a   <= w_shifted[2*N-1:N];
                    r_q   <= w_shifted[N-1:0];
                    r_cnt <= r_cnt - c_CNT_W'(1);
                    // The final iteration's shifted {A,Q} is the product.
                    if (w_last) begin
                        r_product <= w_shifted[2*N-1:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign product = r_product;

endmodule
`default_nettype wire

// File: tb/tb_shift_add_multiplier.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_shift_add_multiplier
// Purpose  : Scoreboard bench for shift_add_multiplier (N=4). Stimulus pushes
//            hand-computed products; a monitor pops and compares on done.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_add_multiplier;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [N-1:0]   mcand;
    logic [N-1:0]   mplier;
    logic           busy;
    logic           done;
    logic [2*N-1:0] product;

    always #5 clk = ~clk;

    shift_add_multiplier #(
        .N       (N)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .mcand   (mcand),
        .mplier  (mplier),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    typedef struct {
        logic [2*N-1:0] prod;
        int             issued;
    } exp_t;

    exp_t           sb[$];
    int             total       = 0;
    int             bad         = 0;
    int             cyc         = 0;
    logic           rst_at_edge = 1'b0;
    logic [2*N-1:0] exp_hold    = '0;
    bit             mon_en      = 1'b0;
    logic           done_prev   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        rst_at_edge = rst;
    end

    // Monitor: compare on every done pulse, otherwise check the held product.
    always @(negedge clk) begin
        if (mon_en) begin
            if (rst_at_edge) begin
                sb.delete();
                exp_hold = '0;
            end
            if (done === 1'b1) begin
                chk("done_width", {31'd0, done_prev}, 32'd0);
                chk("busy_with_done", {31'd0, busy}, 32'd1);
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: actual=done required=no_done product=%0h", product);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("product", {24'd0, product}, {24'd0, e.prod});
                    chk("latency", cyc - e.issued + 1, N + 1);
                    exp_hold = e.prod;
                end
            end else begin
                chk("product_hold", {24'd0, product}, {24'd0, exp_hold});
            end
            done_prev = done;
        end
    end

    // inj > 0: pulse a foreign start inj cycles into CALC (must be ignored).
    task automatic mul(input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [2*N-1:0] p, input int inj);
        int n;
        @(negedge clk);
        mcand  = a;
        mplier = b;
        start  = 1'b1;
        sb.push_back('{prod: p, issued: cyc + 1});
        @(negedge clk);
        start  = 1'b0;
        mcand  = N'($urandom);
        mplier = N'($urandom);
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        if (inj > 0) begin
            for (int i = 1; i < inj; i++) @(negedge clk);
            start  = 1'b1;
            mcand  = 4'd2;
            mplier = 4'd3;
            @(negedge clk);
            start  = 1'b0;
        end
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL timeout: actual=no_done required=done a=%0d b=%0d", a, b);
            sb.delete();
        end
        @(negedge clk);
        chk("busy_after_done", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        mcand  = '0;
        mplier = '0;

        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("reset_busy", {31'd0, busy}, 32'd0);
            chk("reset_done", {31'd0, done}, 32'd0);
            chk("reset_product", {24'd0, product}, 32'd0);
        end
        rst    = 1'b0;
        mon_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_busy", {31'd0, busy}, 32'd0);
            chk("idle_done", {31'd0, done}, 32'd0);
        end

        mul(4'd13, 4'd11, 8'h8F, 0);
        mul(4'd15, 4'd15, 8'hE1, 0);
        mul(4'd0,  4'd9,  8'h00, 0);
        mul(4'd9,  4'd0,  8'h00, 0);
        mul(4'd5,  4'd7,  8'd35, 2);

        // Reset during the second CALC cycle aborts the operation.
        @(negedge clk);
        mcand  = 4'd12;
        mplier = 4'd12;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        @(negedge clk);
        rst    = 1'b1;
        @(negedge clk);
        rst    = 1'b0;
        chk("midreset_busy", {31'd0, busy}, 32'd0);
        chk("midreset_done", {31'd0, done}, 32'd0);
        chk("midreset_product", {24'd0, product}, 32'd0);
        repeat (6) @(negedge clk);

        mul(4'd6,  4'd7,  8'd42,  0);
        mul(4'd8,  4'd15, 8'd120, 0);
        mul(4'd1,  4'd1,  8'd1,   0);
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
